wbctimeout: RTL and testbench



---
 rtl/wbctimeout.sv | 125 ++++++++++++
 tb/tb_wbctimeout.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbctimeout.sv
// wbctimeout: registered Wishbone classic bridge between one crossbar slave
// port and a single peripheral. Every request is re-timed by one cycle, and a
// peripheral that stays silent for TIMEOUT cycles is answered with an error,
// so a hung or unmapped device can never hold a master's grant indefinitely.
module wbctimeout #(
  parameter int AW      = 29,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  // upstream request from the crossbar
  input  logic          i_cyc,
  input  logic          i_stb,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic [SW-1:0] i_sel,
  // upstream response to the crossbar
  output logic          o_ack,
  output logic          o_err,
  output logic [DW-1:0] o_data,
  // downstream request to the peripheral
  output logic          o_scyc,
  output logic          o_sstb,
  output logic          o_swe,
  output logic [AW-1:0] o_saddr,
  output logic [DW-1:0] o_sdata,
  output logic [SW-1:0] o_ssel,
  // downstream response from the peripheral
  input  logic          i_sack,
  input  logic          i_serr,
  input  logic [DW-1:0] i_sdata,
  // one-cycle pulse whenever the bridge gives up on the peripheral
  output logic          o_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  // The counter leaves REQ when it reaches this value, so it never wraps.
  localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] count;

  // Bridge state machine: accept in IDLE, wait for response/abort/timeout in REQ, drop the response pulse in RESP.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      count     <= '0;
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      o_data    <= '0;
      o_scyc    <= 1'b0;
      o_sstb    <= 1'b0;
      o_swe     <= 1'b0;
      o_saddr   <= '0;
      o_sdata   <= '0;
      o_ssel    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cyc && i_stb) begin
            o_swe   <= i_we;
            o_saddr <= i_addr;
            o_sdata <= i_data;
            o_ssel  <= i_sel;
            o_scyc  <= 1'b1;
            o_sstb  <= 1'b1;
            count   <= '0;
            state   <= REQ;
          end
        end

        REQ: begin
          if (!i_cyc) begin
            o_scyc <= 1'b0;
            o_sstb <= 1'b0;
            state  <= IDLE;
          end else if (i_serr) begin
            o_scyc <= 1'b0;
            o_sstb <= 1'b0;
            o_err  <= 1'b1;
            o_data <= '0;
            state  <= RESP;
          end else if (i_sack) begin
            o_scyc <= 1'b0;
            o_sstb <= 1'b0;
            o_ack  <= 1'b1;
            o_data <= i_sdata;
            state  <= RESP;
          end else if (count == LAST_COUNT) begin
            o_scyc    <= 1'b0;
            o_sstb    <= 1'b0;
            o_err     <= 1'b1;
            o_timeout <= 1'b1;
            o_data    <= '0;
            state     <= RESP;
          end else begin
            count <= count + 1'b1;
          end
        end

        RESP: begin
          o_ack     <= 1'b0;
          o_err     <= 1'b0;
          o_timeout <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbctimeout.sv
// tb_wbctimeout: directed-vector bench for wbctimeout with a transaction-level
// reference model compared on every falling clock edge, plus literal
// expectations at the key points of each scenario.
module tb_wbctimeout;

  localparam int AW = 29;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_cyc = 1'b0;
  logic          i_stb = 1'b0;
  logic          i_we = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_data = '0;
  logic [SW-1:0] i_sel = '0;
  logic          i_sack = 1'b0;
  logic          i_serr = 1'b0;
  logic [DW-1:0] i_sdata = '0;

  logic          o_ack;
  logic          o_err;
  logic [DW-1:0] o_data;
  logic          o_scyc;
  logic          o_sstb;
  logic          o_swe;
  logic [AW-1:0] o_saddr;
  logic [DW-1:0] o_sdata;
  logic [SW-1:0] o_ssel;
  logic          o_timeout;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  wbctimeout #(
    .AW(AW),
    .DW(DW),
    .SW(SW),
    .TIMEOUT(TO)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_cyc(i_cyc),
    .i_stb(i_stb),
    .i_we(i_we),
    .i_addr(i_addr),
    .i_data(i_data),
    .i_sel(i_sel),
    .o_ack(o_ack),
    .o_err(o_err),
    .o_data(o_data),
    .o_scyc(o_scyc),
    .o_sstb(o_sstb),
    .o_swe(o_swe),
    .o_saddr(o_saddr),
    .o_sdata(o_sdata),
    .o_ssel(o_ssel),
    .i_sack(i_sack),
    .i_serr(i_serr),
    .i_sdata(i_sdata),
    .o_timeout(o_timeout)
  );

  // Free-running clock, period 10.
  always #5 i_clk = ~i_clk;

  // Reference model: tracks the transaction in flight and how many cycles the
  // strobe has been shown to the peripheral; outputs follow from that.
  logic          m_busy = 1'b0;
  int            m_age = 0;
  logic          m_ack = 1'b0;
  logic          m_err = 1'b0;
  logic          m_to = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [SW-1:0] m_sel = '0;

  // Model update: a response pulse lasts one cycle and blocks acceptance; otherwise serve or accept.
  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_busy  <= 1'b0;
      m_age   <= 0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_to    <= 1'b0;
      m_data  <= '0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_sel   <= '0;
    end else if (m_ack || m_err) begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      m_to  <= 1'b0;
    end else if (m_busy) begin
      if (!i_cyc) begin
        m_busy <= 1'b0;
      end else if (i_serr) begin
        m_busy <= 1'b0;
        m_err  <= 1'b1;
        m_data <= '0;
      end else if (i_sack) begin
        m_busy <= 1'b0;
        m_ack  <= 1'b1;
        m_data <= i_sdata;
      end else if (m_age == TO) begin
        m_busy <= 1'b0;
        m_err  <= 1'b1;
        m_to   <= 1'b1;
        m_data <= '0;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (i_cyc && i_stb) begin
      m_busy  <= 1'b1;
      m_age   <= 1;
      m_we    <= i_we;
      m_addr  <= i_addr;
      m_wdata <= i_data;
      m_sel   <= i_sel;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every falling edge, compare all DUT outputs against the model.
  always @(negedge i_clk) begin
    if (cmp_en) begin
      checkOutput("m_ack", 32'(o_ack), 32'(m_ack));
      checkOutput("m_err", 32'(o_err), 32'(m_err));
      checkOutput("m_timeout", 32'(o_timeout), 32'(m_to));
      checkOutput("m_data", o_data, m_data);
      checkOutput("m_scyc", 32'(o_scyc), 32'(m_busy));
      checkOutput("m_sstb", 32'(o_sstb), 32'(m_busy));
      checkOutput("m_swe", 32'(o_swe), 32'(m_we));
      checkOutput("m_saddr", 32'(o_saddr), 32'(m_addr));
      checkOutput("m_sdata", o_sdata, m_wdata);
      checkOutput("m_ssel", 32'(o_ssel), 32'(m_sel));
    end
  end

  // Drive one cycle's worth of inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [SW-1:0] sel, input logic sack,
                               input logic serr, input logic [DW-1:0] sdata);
    i_cyc   = cyc;
    i_stb   = stb;
    i_we    = we;
    i_addr  = addr;
    i_data  = data;
    i_sel   = sel;
    i_sack  = sack;
    i_serr  = serr;
    i_sdata = sdata;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    #2;
    i_reset = 1'b0;
    cmp_en  = 1'b1;
    #20;
    checkOutput("reset_sstb", 32'(o_sstb), 32'd0);
    checkOutput("reset_ack", 32'(o_ack), 32'd0);
    checkOutput("reset_data", o_data, 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    idleCycle();

    $display("[TB] read");
    applyStimulus(1'b1, 1'b1, 1'b0, 29'h10, '0, 4'hF, 1'b0, 1'b0, '0);
    checkOutput("read_sstb", 32'(o_sstb), 32'd1);
    checkOutput("read_saddr", 32'(o_saddr), 32'h10);
    applyStimulus(1'b1, 1'b1, 1'b0, 29'h10, '0, 4'hF, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 29'h10, '0, 4'hF, 1'b0, 1'b0, '0);
    checkOutput("read_noack_early", 32'(o_ack), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 29'h10, '0, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF);
    checkOutput("read_ack", 32'(o_ack), 32'd1);
    checkOutput("read_data", o_data, 32'hDEADBEEF);
    checkOutput("read_err", 32'(o_err), 32'd0);
    idleCycle();
    checkOutput("read_ack_one_cycle", 32'(o_ack), 32'd0);
    checkOutput("read_data_hold", o_data, 32'hDEADBEEF);

    $display("[TB] write");
    applyStimulus(1'b1, 1'b1, 1'b1, 29'h20, 32'h12345678, 4'b0011, 1'b0, 1'b0, '0);
    checkOutput("write_swe", 32'(o_swe), 32'd1);
    checkOutput("write_sdata", o_sdata, 32'h12345678);
    checkOutput("write_ssel", 32'(o_ssel), 32'h3);
    applyStimulus(1'b1, 1'b1, 1'b1, 29'h20, 32'h12345678, 4'b0011, 1'b1, 1'b0, '0);
    checkOutput("write_ack", 32'(o_ack), 32'd1);
    idleCycle();
    idleCycle();

    $display("[TB] ack with error");
    applyStimulus(1'b1, 1'b1, 1'b0, 29'h30, '0, 4'hF, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 29'h30, '0, 4'hF, 1'b1, 1'b1, 32'hFFFF0000);
    checkOutput("both_err", 32'(o_err), 32'd1);
    checkOutput("both_ack", 32'(o_ack), 32'd0);
    checkOutput("both_data", o_data, 32'd0);
    idleCycle();
    idleCycle();

    $display("[TB] timeout");
    applyStimulus(1'b1, 1'b1, 1'b0, 29'h40, '0, 4'hF, 1'b0, 1'b0, '0);
    for (int i = 1; i <= TO; i++) begin
      checkOutput("to_sstb_high", 32'(o_sstb), 32'd1);
      checkOutput("to_no_err", 32'(o_err), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 29'h40, '0, 4'hF, 1'b0, 1'b0, '0);
    end
    checkOutput("to_sstb_low", 32'(o_sstb), 32'd0);
    checkOutput("to_err", 32'(o_err), 32'd1);
    checkOutput("to_pulse", 32'(o_timeout), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'h11111111);
    checkOutput("to_pulse_end", 32'(o_timeout), 32'd0);
    checkOutput("to_late_ack", 32'(o_ack), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'h11111111);
    checkOutput("to_late_ack2", 32'(o_ack), 32'd0);
    idleCycle();

    $display("[TB] abort");
    applyStimulus(1'b1, 1'b1, 1'b0, 29'h50, '0, 4'hF, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 29'h50, '0, 4'hF, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 29'h50, '0, 4'hF, 1'b0, 1'b0, '0);
    checkOutput("abort_scyc", 32'(o_scyc), 32'd0);
    checkOutput("abort_ack", 32'(o_ack), 32'd0);
    checkOutput("abort_err", 32'(o_err), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 29'h60, '0, 4'hF, 1'b0, 1'b0, '0);
    checkOutput("abort_new_sstb", 32'(o_sstb), 32'd1);
    checkOutput("abort_new_saddr", 32'(o_saddr), 32'h60);
    applyStimulus(1'b1, 1'b1, 1'b0, 29'h60, '0, 4'hF, 1'b1, 1'b0, 32'hA5A5A5A5);
    checkOutput("abort_new_ack", 32'(o_ack), 32'd1);
    checkOutput("abort_new_data", o_data, 32'hA5A5A5A5);
    idleCycle();

    $display("[TB] reset mid-transaction");
    applyStimulus(1'b1, 1'b1, 1'b1, 29'h44, 32'h0BADF00D, 4'hC, 1'b0, 1'b0, '0);
    checkOutput("rst_pre_sstb", 32'(o_sstb), 32'd1);
    #2;
    i_reset = 1'b0;
    #1;
    checkOutput("rst_async_scyc", 32'(o_scyc), 32'd0);
    checkOutput("rst_async_sstb", 32'(o_sstb), 32'd0);
    checkOutput("rst_async_saddr", 32'(o_saddr), 32'd0);
    checkOutput("rst_async_sdata", o_sdata, 32'd0);
    checkOutput("rst_async_data", o_data, 32'd0);
    i_cyc = 1'b0;
    i_stb = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    idleCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 29'h55, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, '0);
    checkOutput("rst_after_saddr", 32'(o_saddr), 32'h55);
    applyStimulus(1'b1, 1'b1, 1'b1, 29'h55, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h00C0FFEE);
    checkOutput("rst_after_ack", 32'(o_ack), 32'd1);
    checkOutput("rst_after_data", o_data, 32'h00C0FFEE);
    idleCycle();
    idleCycle();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
